// File: rtl/mem_port_arbiter.sv
// Two-port (I/D) to single pmem port arbiter.
// D-side wins by default; a streak limit keeps I from starving.
module mem_port_arbiter #(
  parameter int WIDTH        = 16,
  parameter int MAX_D_STREAK = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] I_mem_address,
  input  logic             I_mem_read,
  output logic             I_mem_resp,
  output logic [WIDTH-1:0] I_mem_rdata,
  input  logic [WIDTH-1:0] D_mem_address,
  input  logic             D_mem_read,
  input  logic             D_mem_write,
  input  logic [1:0]       D_mem_byte_enable,
  input  logic [WIDTH-1:0] D_mem_wdata,
  output logic             D_mem_resp,
  output logic [WIDTH-1:0] D_mem_rdata,
  output logic [WIDTH-1:0] pmem_address,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [1:0]       pmem_wmask,
  output logic [WIDTH-1:0] pmem_wdata,
  input  logic             pmem_resp,
  input  logic [WIDTH-1:0] pmem_rdata
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_D_STREAK);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } state_e;

  state_e           state_q;
  logic [SW-1:0]    streak_q;
  logic             i_resp_q;
  logic             d_resp_q;
  logic [WIDTH-1:0] i_rdata_q;
  logic [WIDTH-1:0] d_rdata_q;
  logic [WIDTH-1:0] addr_q;
  logic             rd_q;
  logic             wr_q;
  logic [1:0]       wmask_q;
  logic [WIDTH-1:0] wdata_q;

  logic             d_pend;
  logic             i_forced;
  logic             d_win;
  logic             i_win;
  logic [SW-1:0]    streak_d;

  always_comb begin
    d_pend   = D_mem_read | D_mem_write;
    i_forced = I_mem_read && (streak_q == SMAX);
    d_win    = d_pend && !i_forced;
    i_win    = I_mem_read && !d_win;
    streak_d = '0;
    if (I_mem_read)
      streak_d = (streak_q == SMAX) ? streak_q
                                    : streak_q + SW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wmask_q   <= '0;
      wdata_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            d_win: begin
              state_q  <= BUSY_D;
              streak_q <= streak_d;
              addr_q   <= D_mem_address;
              wr_q     <= D_mem_write;
              rd_q     <= !D_mem_write;
              wmask_q  <= D_mem_write ? D_mem_byte_enable
                                      : 2'b11;
              wdata_q  <= D_mem_write ? D_mem_wdata
                                      : '0;
            end
            i_win: begin
              state_q  <= BUSY_I;
              streak_q <= '0;
              addr_q   <= I_mem_address;
              wr_q     <= 1'b0;
              rd_q     <= 1'b1;
              wmask_q  <= 2'b11;
              wdata_q  <= '0;
            end
            default: state_q <= IDLE;
          endcase
        end
        BUSY_I: begin
          if (pmem_resp) begin
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            i_rdata_q <= pmem_rdata;
            i_resp_q  <= 1'b1;
            state_q   <= RESP_I;
          end
        end
        BUSY_D: begin
          if (pmem_resp) begin
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            d_rdata_q <= pmem_rdata;
            d_resp_q  <= 1'b1;
            state_q   <= RESP_D;
          end
        end
        RESP_I: begin
          i_resp_q <= 1'b0;
          state_q  <= IDLE;
        end
        RESP_D: begin
          d_resp_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign I_mem_resp   = i_resp_q;
  assign I_mem_rdata  = i_rdata_q;
  assign D_mem_resp   = d_resp_q;
  assign D_mem_rdata  = d_rdata_q;
  assign pmem_address = addr_q;
  assign pmem_read    = rd_q;
  assign pmem_write   = wr_q;
  assign pmem_wmask   = wmask_q;
  assign pmem_wdata   = wdata_q;

endmodule
